il2_inst_refill_responder: RTL

- L2-side responder for the instruction L1 miss/refill protocol, clocked in the L2 domain.
- Accepts a one-cycle miss trigger plus miss PC from the IL1 controller and performs the L2 lookup.
- If the L2 victim line is inclusive-resident in IL1, back-invalidates it through the inst_replace_sync/solve handshake before refilling.
- Streams the refill line to IL1 critical-word-first under a held update strobe.

---
 rtl/il2_inst_refill_responder.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/il2_inst_refill_responder.sv
// L2-side responder for IL1 misses: lookup, optional inclusive back-invalidate,
// then a critical-word-first refill stream under a held update strobe.
module il2_inst_refill_responder #(
   parameter int PC_LENGTH   = 32,
   parameter int INST_LENGTH = 32,
   parameter int LINE_WORDS  = 16,
   parameter int IDX_W       = 6,
   parameter int BYTE_OFFSET = 2
) (
   input  logic                          clk_l2,
   input  logic                          rst_n,
   input  logic                          req_trigger,
   input  logic [PC_LENGTH-1:0]          req_pc,
   output logic                          lookup_req,
   output logic [PC_LENGTH-1:0]          lookup_addr,
   input  logic                          lookup_done,
   input  logic                          lookup_evict,
   input  logic [IDX_W-1:0]              victim_index,
   output logic                          inst_replace_sync,
   output logic [IDX_W-1:0]              inclusive_index,
   input  logic                          inst_replace_solve,
   input  logic                          inst_replace_il1_ack_trigger,
   input  logic                          word_valid,
   input  logic [INST_LENGTH-1:0]        word_data,
   output logic                          word_ready,
   output logic                          update,
   output logic [INST_LENGTH-1:0]        update_inst,
   output logic [$clog2(LINE_WORDS)-1:0] update_word_idx,
   output logic                          busy,
   output logic                          req_overflow,
   output logic [7:0]                    backinv_clear_cnt
);

   localparam int WW = $clog2(LINE_WORDS);
   localparam int LO = BYTE_OFFSET + WW;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      BACKINV,
      WAIT_DROP,
      REFILL,
      GAP
   } state_t;

   state_t                 state_q;
   logic [WW-1:0]          start_q;
   logic [WW-1:0]          beat_q;
   logic                   last_q;
   logic                   lookup_req_q;
   logic [PC_LENGTH-1:0]   lookup_addr_q;
   logic                   sync_q;
   logic [IDX_W-1:0]       victim_q;
   logic                   ready_q;
   logic                   update_q;
   logic [INST_LENGTH-1:0] inst_q;
   logic [WW-1:0]          idx_q;
   logic                   ovf_q;
   logic [7:0]             clr_cnt_q;

   logic [WW-1:0]          idx_d;
   logic [7:0]             clr_cnt_d;
   logic [PC_LENGTH-1:0]   line_addr_d;
   logic                   unused_pc_bits;

   assign unused_pc_bits = ^req_pc[LO-1:0];

   always_comb begin
      idx_d       = start_q + beat_q;
      clr_cnt_d   = clr_cnt_q;
      line_addr_d = {req_pc[PC_LENGTH-1:LO], {LO{1'b0}}};
      if (inst_replace_il1_ack_trigger && clr_cnt_q != 8'hFF)
         clr_cnt_d = clr_cnt_q + 8'd1;
   end

   always_ff @(posedge clk_l2 or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         start_q       <= '0;
         beat_q        <= '0;
         last_q        <= 1'b0;
         lookup_req_q  <= 1'b0;
         lookup_addr_q <= '0;
         sync_q        <= 1'b0;
         victim_q      <= '0;
         ready_q       <= 1'b0;
         update_q      <= 1'b0;
         inst_q        <= '0;
         idx_q         <= '0;
         ovf_q         <= 1'b0;
         clr_cnt_q     <= '0;
      end else begin
         clr_cnt_q <= clr_cnt_d;
         if (req_trigger && state_q != IDLE)
            ovf_q <= 1'b1;
         unique case (state_q)
            IDLE: begin
               if (req_trigger) begin
                  start_q       <= req_pc[BYTE_OFFSET +: WW];
                  lookup_addr_q <= line_addr_d;
                  lookup_req_q  <= 1'b1;
                  state_q       <= LOOKUP;
               end
            end
            LOOKUP: begin
               if (lookup_done) begin
                  lookup_req_q <= 1'b0;
                  beat_q       <= '0;
                  last_q       <= 1'b0;
                  if (lookup_evict) begin
                     victim_q <= victim_index;
                     sync_q   <= 1'b1;
                     state_q  <= BACKINV;
                  end else begin
                     update_q <= 1'b1;
                     ready_q  <= 1'b1;
                     state_q  <= REFILL;
                  end
               end
            end
            BACKINV: begin
               if (inst_replace_solve) begin
                  sync_q  <= 1'b0;
                  state_q <= WAIT_DROP;
               end
            end
            WAIT_DROP: begin
               update_q <= 1'b1;
               ready_q  <= 1'b1;
               state_q  <= REFILL;
            end
            REFILL: begin
               // last_q marks the cycle presenting the final word
               if (last_q) begin
                  last_q   <= 1'b0;
                  update_q <= 1'b0;
                  state_q  <= GAP;
               end else if (word_valid && ready_q) begin
                  inst_q <= word_data;
                  idx_q  <= idx_d;
                  beat_q <= beat_q + 1'b1;
                  if (beat_q == WW'(LINE_WORDS - 1)) begin
                     ready_q <= 1'b0;
                     last_q  <= 1'b1;
                  end
               end
            end
            GAP: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign lookup_req        = lookup_req_q;
   assign lookup_addr       = lookup_addr_q;
   assign inst_replace_sync = sync_q;
   assign inclusive_index   = victim_q;
   assign word_ready        = ready_q;
   assign update            = update_q;
   assign update_inst       = inst_q;
   assign update_word_idx   = idx_q;
   assign busy              = (state_q != IDLE);
   assign req_overflow      = ovf_q;
   assign backinv_clear_cnt = clr_cnt_q;

endmodule
